// File: rtl/lcd_bus_responder.sv
// Receiving end of the 4-bit character-LCD bus: decodes E falls into bytes, tracks mode/entry/address.
// Optional busy-time checking is built when LCD_BUS_RESPONDER_BUSY_CHECK_EN is defined.
//   state  | meaning
//   S_8BIT | power-on 8-bit interface, each nibble is a whole command
//   S_HI   | 4-bit interface, waiting for the high nibble
//   S_LO   | 4-bit interface, high nibble held, waiting for the low nibble
module lcd_bus_responder #(
  parameter int MIN_E_HIGH   = 12,
  parameter int CMD_CYCLES   = 2000,
  parameter int CLEAR_CYCLES = 85000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic [3:0] iLCD_Data,
  output logic       oValid,
  output logic [7:0] oByte,
  output logic       oIsData,
  output logic       oMode4,
  output logic [6:0] oAddr,
  output logic       oBusy,
  output logic [2:0] oErr
);

  localparam int EW = $clog2(MIN_E_HIGH + 1);

  typedef enum logic [1:0] {S_8BIT, S_HI, S_LO} stateType;

  stateType      state, stateNext;
  logic          rE, rRS, rRW;
  logic [3:0]    rD;
  logic          rE_d, rRS_d, rRW_d;
  logic [3:0]    rD_d;
  logic [EW-1:0] eHighCnt;
  logic          fallEvent;
  logic          fallQ, rsQ, rwQ, shortQ;
  logic [3:0]    nibQ;
  logic [3:0]    hiNib, hiNibNext;
  logic          hiRs, hiRsNext;
  logic          incr, incrNext;
  logic          mode4Next;
  logic [6:0]    addrNext;
  logic          validNext;
  logic [7:0]    byteNext;
  logic          isDataNext;
  logic [2:0]    errNext;
  logic          exec;
  logic [7:0]    execByte;
  logic          execData;
  logic          busyActive;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rE    <= 1'b0;
      rRS   <= 1'b0;
      rRW   <= 1'b0;
      rD    <= 4'h0;
      rE_d  <= 1'b0;
      rRS_d <= 1'b0;
      rRW_d <= 1'b0;
      rD_d  <= 4'h0;
    end else begin
      rE    <= iLCD_Enabled;
      rRS   <= iLCD_RegisterSelect;
      rRW   <= iLCD_ReadWrite;
      rD    <= iLCD_Data;
      rE_d  <= rE;
      rRS_d <= rRS;
      rRW_d <= rRW;
      rD_d  <= rD;
    end
  end

  assign fallEvent = rE_d & ~rE;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      eHighCnt <= '0;
    end else if (!rE) begin
      eHighCnt <= '0;
    end else if (eHighCnt != EW'(MIN_E_HIGH)) begin
      eHighCnt <= eHighCnt + 1'b1;
    end
  end

  // The _d copies hold the last values seen while E was high.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fallQ  <= 1'b0;
      rsQ    <= 1'b0;
      rwQ    <= 1'b0;
      nibQ   <= 4'h0;
      shortQ <= 1'b0;
    end else begin
      fallQ  <= fallEvent;
      rsQ    <= rRS_d;
      rwQ    <= rRW_d;
      nibQ   <= rD_d;
      shortQ <= fallEvent && (eHighCnt < EW'(MIN_E_HIGH));
    end
  end

  always_comb begin
    stateNext  = state;
    hiNibNext  = hiNib;
    hiRsNext   = hiRs;
    incrNext   = incr;
    mode4Next  = oMode4;
    addrNext   = oAddr;
    validNext  = 1'b0;
    byteNext   = oByte;
    isDataNext = oIsData;
    errNext    = 3'b000;
    exec       = 1'b0;
    execByte   = 8'h00;
    execData   = 1'b0;

    if (fallQ) begin
      errNext[0] = shortQ;
      if (rwQ) begin
        errNext[2] = 1'b1;
      end else begin
        errNext[1] = busyActive;
        case (state)
          S_8BIT: begin
            if (nibQ == 4'h2 || (nibQ == 4'h3 && !oMode4)) begin
              exec     = 1'b1;
              execByte = {nibQ, 4'h0};
              if (nibQ == 4'h2) begin
                mode4Next = 1'b1;
                stateNext = S_HI;
              end
            end
          end
          S_HI: begin
            hiNibNext = nibQ;
            hiRsNext  = rsQ;
            stateNext = S_LO;
          end
          S_LO: begin
            exec      = 1'b1;
            execByte  = {hiNib, nibQ};
            execData  = hiRs;
            stateNext = S_HI;
          end
          default: stateNext = S_8BIT;
        endcase
      end
    end

    if (exec) begin
      validNext  = 1'b1;
      byteNext   = execByte;
      isDataNext = execData;
      if (execData) begin
        addrNext = incr ? oAddr + 7'd1 : oAddr - 7'd1;
      end else if (execByte == 8'h01) begin
        addrNext = 7'h00;
        incrNext = 1'b1;
      end else if (execByte[7:1] == 7'b0000001) begin
        addrNext = 7'h00;
      end else if (execByte[7:2] == 6'b000001) begin
        incrNext = execByte[1];
      end else if (execByte[7]) begin
        addrNext = execByte[6:0];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= S_8BIT;
      hiNib   <= 4'h0;
      hiRs    <= 1'b0;
      incr    <= 1'b1;
      oMode4  <= 1'b0;
      oAddr   <= 7'h00;
      oValid  <= 1'b0;
      oByte   <= 8'h00;
      oIsData <= 1'b0;
      oErr    <= 3'b000;
    end else begin
      state   <= stateNext;
      hiNib   <= hiNibNext;
      hiRs    <= hiRsNext;
      incr    <= incrNext;
      oMode4  <= mode4Next;
      oAddr   <= addrNext;
      oValid  <= validNext;
      oByte   <= byteNext;
      oIsData <= isDataNext;
      oErr    <= errNext;
    end
  end

`ifdef LCD_BUS_RESPONDER_BUSY_CHECK_EN
  logic [31:0] busyCnt;
  logic        clearClass;

  assign clearClass = !execData && (execByte[7:2] == 6'd0) && (execByte[1:0] != 2'd0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      busyCnt <= 32'd0;
    end else if (exec) begin
      busyCnt <= clearClass ? 32'(CLEAR_CYCLES) : 32'(CMD_CYCLES);
    end else if (busyCnt != 32'd0) begin
      busyCnt <= busyCnt - 32'd1;
    end
  end

  // A count of 1 reaches zero on the same edge, so that access is not busy.
  assign busyActive = busyCnt > 32'd1;
  assign oBusy      = busyCnt != 32'd0;
`else
  assign busyActive = 1'b0;
  assign oBusy      = 1'b0;
`endif

endmodule
